// File: rtl/pulse_peak_detector_pkg.sv
// Shared settings and types for the per-channel pulse peak detector.
package pulse_peak_detector_pkg;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int SIZE_TIMESTAMP   = 32;
    localparam int SIZE_PEAK_WIDTH  = 8;
    localparam int PEAK_HOLDOFF     = 16;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        HOLDOFF
    } peak_state_t;

    // "time" is a reserved word, hence peak_ts for the timestamp field.
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic        [SIZE_TIMESTAMP-1:0]   peak_ts;
        logic        [SIZE_PEAK_WIDTH-1:0]  width;
        logic                               pileup;
    } peak_event_t;

endpackage

// File: rtl/pulse_peak_detector_tracker.sv
// Running maximum, timestamp of its first occurrence and above-threshold width.
module pulse_peak_detector_tracker
    import pulse_peak_detector_pkg::*;
#(
    parameter int DATA_W  = SIZE_FILTER_DATA,
    parameter int TS_W    = SIZE_TIMESTAMP,
    parameter int WIDTH_W = SIZE_PEAK_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      load,
    input  logic                      update,
    input  logic signed [DATA_W-1:0]  sample,
    input  logic        [TS_W-1:0]    sample_ts,
    output logic signed [DATA_W-1:0]  max_amp,
    output logic        [TS_W-1:0]    max_ts,
    output logic        [WIDTH_W-1:0] width
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_amp <= '0;
            max_ts  <= '0;
            width   <= '0;
        end else if (clear) begin
            max_amp <= '0;
            max_ts  <= '0;
            width   <= '0;
        end else if (load) begin
            max_amp <= sample;
            max_ts  <= sample_ts;
            width   <= WIDTH_W'(1);
        end else if (update) begin
            width <= width + WIDTH_W'(1);
            // strict compare keeps the earliest of equal maxima
            if (sample > max_amp) begin
                max_amp <= sample;
                max_ts  <= sample_ts;
            end
        end
    end

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold-crossing pulse detector: reports peak amplitude, peak timestamp,
// width and pile-up per event, followed by a fixed dead time.
module pulse_peak_detector
    import pulse_peak_detector_pkg::*;
#(
    parameter int DATA_W      = SIZE_FILTER_DATA,
    parameter int TS_W        = SIZE_TIMESTAMP,
    parameter int WIDTH_W     = SIZE_PEAK_WIDTH,
    parameter int HOLDOFF_LEN = PEAK_HOLDOFF,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [DATA_W-1:0]  input_data,
    input  logic signed [DATA_W-1:0]  threshold,
    input  logic                      enable,
    output logic                      peak_valid,
    output logic signed [DATA_W-1:0]  peak_amp,
    output logic        [TS_W-1:0]    peak_time,
    output logic        [WIDTH_W-1:0] peak_width,
    output logic                      pileup,
    output logic                      busy,
    output logic        [CNT_W-1:0]   event_count
);

    localparam int HC_W = $clog2(HOLDOFF_LEN + 1);

    logic signed [DATA_W-1:0]  d_r;
    logic signed [DATA_W-1:0]  thr_r;
    logic        [TS_W-1:0]    ts;
    logic        [TS_W-1:0]    ts_r;
    logic        [HC_W-1:0]    hold_cnt;
    peak_state_t               state;
    peak_state_t               state_nx;

    logic                      trk_clear;
    logic                      trk_load;
    logic                      trk_update;
    logic signed [DATA_W-1:0]  trk_max;
    logic        [TS_W-1:0]    trk_ts;
    logic        [WIDTH_W-1:0] trk_width;

    logic                      thr_load;
    logic                      emit;
    logic                      emit_pileup;
    logic                      emit_r;
    logic                      emit_pileup_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_r  <= '0;
            ts   <= '0;
            ts_r <= '0;
        end else begin
            d_r  <= input_data;
            ts   <= ts + TS_W'(1);
            ts_r <= ts;
        end
    end

    pulse_peak_detector_tracker #(
        .DATA_W  (DATA_W),
        .TS_W    (TS_W),
        .WIDTH_W (WIDTH_W)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .clear     (trk_clear),
        .load      (trk_load),
        .update    (trk_update),
        .sample    (d_r),
        .sample_ts (ts_r),
        .max_amp   (trk_max),
        .max_ts    (trk_ts),
        .width     (trk_width)
    );

    always_comb begin
        state_nx    = state;
        trk_clear   = 1'b0;
        trk_load    = 1'b0;
        trk_update  = 1'b0;
        thr_load    = 1'b0;
        emit        = 1'b0;
        emit_pileup = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (d_r > threshold)) begin
                    trk_load = 1'b1;
                    thr_load = 1'b1;
                    state_nx = RISE;
                end
            end
            RISE: begin
                if (!enable) begin
                    trk_clear = 1'b1;
                    state_nx  = IDLE;
                end else if (!(d_r > thr_r)) begin
                    emit     = 1'b1;
                    state_nx = HOLDOFF;
                end else if (trk_width == '1) begin
                    emit        = 1'b1;
                    emit_pileup = 1'b1;
                    state_nx    = HOLDOFF;
                end else begin
                    trk_update = 1'b1;
                end
            end
            HOLDOFF: begin
                if (hold_cnt == HC_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            thr_r    <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_nx;
            if (thr_load) begin
                thr_r <= threshold;
            end
            if (emit) begin
                hold_cnt <= HC_W'(HOLDOFF_LEN);
            end else if (state == HOLDOFF) begin
                hold_cnt <= hold_cnt - HC_W'(1);
            end
        end
    end

    // Tracker is frozen during HOLDOFF, so it is read one cycle after emit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            emit_r        <= 1'b0;
            emit_pileup_r <= 1'b0;
            peak_valid    <= 1'b0;
            peak_amp      <= '0;
            peak_time     <= '0;
            peak_width    <= '0;
            pileup        <= 1'b0;
            event_count   <= '0;
        end else begin
            emit_r        <= emit;
            emit_pileup_r <= emit_pileup;
            peak_valid    <= emit_r;
            if (emit_r) begin
                peak_amp   <= trk_max;
                peak_time  <= trk_ts;
                peak_width <= trk_width;
                pileup     <= emit_pileup_r;
                if (event_count != '1) begin
                    event_count <= event_count + CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Scoreboard bench for pulse_peak_detector with directed pulse shapes.
module tb_pulse_peak_detector;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [15:0] input_data = '0;
    logic signed [15:0] threshold = 16'sd100;
    logic               enable = 1'b1;
    logic               peak_valid;
    logic signed [15:0] peak_amp;
    logic        [31:0] peak_time;
    logic        [7:0]  peak_width;
    logic               pileup;
    logic               busy;
    logic        [15:0] event_count;

    pulse_peak_detector #(
        .DATA_W      (16),
        .TS_W        (32),
        .WIDTH_W     (8),
        .HOLDOFF_LEN (16),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .threshold   (threshold),
        .enable      (enable),
        .peak_valid  (peak_valid),
        .peak_amp    (peak_amp),
        .peak_time   (peak_time),
        .peak_width  (peak_width),
        .pileup      (pileup),
        .busy        (busy),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] amp;
        logic        [31:0] ts;
        logic        [7:0]  width;
        logic               pileup;
        logic        [15:0] count;
        logic        [31:0] edge_no;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // edges since reset release; equals the DUT timestamp of a sample driven now
    logic [31:0] edge_cnt;
    logic [31:0] last_ts;
    logic [31:0] last_edge;
    logic [31:0] ts_a;
    logic [31:0] ts_b;

    int t1_vals [9] = '{0, 50, 150, 300, 420, 420, 200, 90, 0};

    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= '0;
        else        edge_cnt <= edge_cnt + 32'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic signed [15:0] v);
        input_data = v;
        last_ts    = edge_cnt;
        last_edge  = edge_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic signed [15:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(v);
    endtask

    // term_edge: edge index of the sample that ends the event; strobe follows two edges later
    task automatic push(input logic signed [15:0] amp, input logic [31:0] ts,
                        input logic [7:0] width, input logic pile,
                        input logic [15:0] count, input logic [31:0] term_edge);
        exp_t e;
        e.amp     = amp;
        e.ts      = ts;
        e.width   = width;
        e.pileup  = pile;
        e.count   = count;
        e.edge_no = term_edge + 32'd3;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset && peak_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: peak_valid=1 amp %0d width %0d, none required",
                         peak_amp, peak_width);
            end else begin
                mon_e = sb.pop_front();
                check("peak_amp",    64'(peak_amp),    64'(mon_e.amp));
                check("peak_time",   64'(peak_time),   64'(mon_e.ts));
                check("peak_width",  64'(peak_width),  64'(mon_e.width));
                check("pileup",      64'(pileup),      64'(mon_e.pileup));
                check("event_count", 64'(event_count), 64'(mon_e.count));
                check("strobe_edge", 64'(edge_cnt),    64'(mon_e.edge_no));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  64'(peak_valid),  64'd0);
        check({tag, "_amp"},    64'(peak_amp),    64'd0);
        check({tag, "_time"},   64'(peak_time),   64'd0);
        check({tag, "_width"},  64'(peak_width),  64'd0);
        check({tag, "_pileup"}, 64'(pileup),      64'd0);
        check({tag, "_busy"},   64'(busy),        64'd0);
        check({tag, "_count"},  64'(event_count), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(0, 3);

        // single pulse with a repeated maximum
        for (int i = 0; i < 9; i++) begin
            drive(16'(t1_vals[i]));
            if (i == 4) ts_a = last_ts;
            if (i == 7) push(16'sd420, ts_a, 8'd5, 1'b0, 16'd1, last_edge);
        end
        idle(0, 20);

        // negative threshold, signed comparison
        idle(-100, 3);
        threshold = -16'sd50;
        idle(-100, 2);
        drive(-16'sd20);
        drive(-16'sd10);
        ts_a = last_ts;
        drive(-16'sd60);
        push(-16'sd10, ts_a, 8'd2, 1'b0, 16'd2, last_edge);
        idle(-100, 20);
        threshold = 16'sd100;
        idle(-100, 2);
        idle(0, 3);

        // long pulse: pile-up at 255, then re-trigger after dead time
        for (int i = 0; i < 300; i++) begin
            drive(16'sd500);
            if (i == 0)   ts_a = last_ts;
            if (i == 255) push(16'sd500, ts_a, 8'd255, 1'b1, 16'd3, last_edge);
            if (i == 272) ts_b = last_ts;
        end
        drive(0);
        push(16'sd500, ts_b, 8'd28, 1'b0, 16'd4, last_edge);
        idle(0, 20);

        // second pulse inside dead time is ignored
        drive(16'sd200);
        drive(16'sd300);
        ts_a = last_ts;
        drive(16'sd50);
        push(16'sd300, ts_a, 8'd2, 1'b0, 16'd5, last_edge);
        idle(0, 9);
        idle(400, 3);
        idle(0, 20);
        check("holdoff_ignore_count", 64'(event_count), 64'd5);

        // second pulse exactly at the end of dead time is reported
        drive(16'sd200);
        ts_a = last_ts;
        drive(16'sd50);
        push(16'sd200, ts_a, 8'd1, 1'b0, 16'd6, last_edge);
        idle(0, 16);
        drive(16'sd350);
        ts_b = last_ts;
        drive(0);
        push(16'sd350, ts_b, 8'd1, 1'b0, 16'd7, last_edge);
        idle(0, 20);

        // enable dropped during RISE aborts silently
        drive(16'sd200);
        drive(16'sd300);
        drive(16'sd300);
        check("rise_busy", 64'(busy), 64'd1);
        enable = 1'b0;
        idle(300, 2);
        check("abort_busy", 64'(busy), 64'd0);
        idle(0, 3);
        enable = 1'b1;
        idle(0, 5);
        check("abort_count", 64'(event_count), 64'd7);

        // reset mid-pulse discards the event
        drive(16'sd200);
        drive(16'sd300);
        drive(16'sd300);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        input_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("postreset_count", 64'(event_count), 64'd0);
        idle(0, 3);

        // timestamp wraps inside a pulse; equal-to-threshold sample ends it
        force dut.ts = 32'hFFFF_FFFE;
        #1;
        release dut.ts;
        drive(0);
        drive(16'sd200);
        drive(16'sd300);
        drive(16'sd400);
        drive(16'sd100);
        push(16'sd400, 32'h0000_0001, 8'd3, 1'b0, 16'd1, last_edge);
        idle(0, 25);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_peak_detector.md
Name: pulse_peak_detector

Overview:
- Downstream consumer of one filter output channel (output_data_vN, SIZE_FILTER_DATA bits, signed two's complement).
- Detects pulses by threshold crossing. For each pulse it reports the peak amplitude, a peak timestamp, the width and a pile-up flag, plus a saturating event counter.
- One instance per filter channel sits after the filter top. It feeds the readout/histogramming logic.

Parameters:
- DATA_W, SIZE_FILTER_DATA (package_settings), width of the filter sample.
- TS_W, 32, timestamp counter width.
- WIDTH_W, 8, width-counter bits; MAX_WIDTH = 2**WIDTH_W-1.
- HOLDOFF_LEN, 16, dead-time cycles after each reported event, ≥1.
- CNT_W, 16, event counter width.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset.
- input_data  in  DATA_W  signed filter sample, one per clk.
- threshold  in  DATA_W  signed trigger level; quasi-static, sampled at pulse start.
- enable  in  1  detection enable.
- peak_valid  out  1  one-cycle strobe for a reported event.
- peak_amp  out  DATA_W  maximum sample of the event.
- peak_time  out  TS_W  timestamp of the first occurrence of the maximum.
- peak_width  out  WIDTH_W  number of samples above threshold.
- pileup  out  1  event truncated at MAX_WIDTH.
- busy  out  1  high in RISE or HOLDOFF.
- event_count  out  CNT_W  reported events, saturating.

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, timestamp counter 0.
- Input stage:
  - input_data is registered into d_r every cycle.
  - ts is a free-running TS_W counter that wraps at 2**TS_W-1 → 0.
  - ts_r is captured alongside d_r.
- Comparisons are signed, strict: a sample is "above" when d_r > thr_r.
- IDLE:
  - If enable=1 and d_r > threshold: latch thr_r = threshold, max = d_r, max_ts = ts_r, width = 1, go to RISE.
  - Otherwise stay in IDLE.
- RISE:
  - If d_r > thr_r and width < MAX_WIDTH: width++.
    - If d_r > max, update max and max_ts.
    - On equal values, keep the earlier maximum.
  - If d_r <= thr_r: emit the event with pileup=0 and go to HOLDOFF.
  - If d_r > thr_r and width == MAX_WIDTH: emit the event with pileup=1 and go to HOLDOFF. The current sample is not included in the event.
- Emit:
  - On the next clk, peak_valid=1 for exactly one cycle.
  - peak_amp, peak_time, peak_width and pileup are registered and held until the next emit.
  - event_count increments and saturates at all-ones.
- Latency: the first below-threshold sample presented at input_data at edge k gives peak_valid high after edge k+2.
- HOLDOFF:
  - Down-counter loaded with HOLDOFF_LEN; input is ignored.
  - When the counter reaches 0, go to IDLE. Exactly HOLDOFF_LEN cycles are spent in HOLDOFF.
  - Re-trigger in IDLE requires a fresh above-threshold sample. A level still above threshold re-triggers immediately.
- enable deasserted:
  - In RISE: abort with no emit, go to IDLE, and clear width and max.
  - In HOLDOFF: the countdown continues.
- threshold changes mid-pulse have no effect; thr_r is used until the event ends.
- Timestamp wrap is not flagged; consumers handle modulo arithmetic.
- Reset asserted mid-pulse: the event is discarded, no peak_valid, and all state returns to reset values.
- busy = (state != IDLE).

Decomposition:
- package_settings:
  - SIZE_FILTER_DATA (existing).
  - New constants SIZE_TIMESTAMP=32, SIZE_PEAK_WIDTH=8, PEAK_HOLDOFF=16.
  - typedef enum logic [1:0] {IDLE, RISE, HOLDOFF} peak_state_t.
  - typedef struct packed peak_event_t {amp, time, width, pileup}.
- One sub-module: peak_tracker. It holds the running max, max_ts and width logic, with clear/load/update controls driven by the FSM in the top.

Test Plan (DATA_W=16, HOLDOFF_LEN=16, WIDTH_W=8):
- Single pulse, threshold=100, samples 0,50,150,300,420,420,200,90,0 → one peak_valid: peak_amp=420, peak_time=ts of the first 420, peak_width=5, pileup=0, event_count=1. The strobe comes 2 cycles after the 90 sample.
- Negative levels, threshold=-50, samples -100,-20,-10,-60 → peak_amp=-10, peak_width=2, signed comparison verified.
- Long pulse, constant 500 above threshold=100 for 300 samples → emit at width=255 with pileup=1, then 16 HOLDOFF cycles, then re-trigger and a second event on the remaining samples.
- Two pulses spaced 10 cycles after the first falls below threshold → the second is ignored (HOLDOFF), event_count=1. With spacing of 17 cycles → two events.
- enable dropped mid-RISE, or reset low mid-pulse → no peak_valid. With reset, all outputs read 0 during reset and event_count=0 after release.
- Preload ts near 2**32-2 (force), pulse spans the wrap → peak_time equals the wrapped value (e.g. 0x00000001) and the event is reported normally.
